// File: rtl/mem_if_pkg.sv
`default_nettype none
//============================================================================
// mem_if_pkg: shared constants and types for the cache-to-memory interface
// Revision: 1.0
//============================================================================
package mem_if_pkg;

   localparam int ADDR_W = 32;
   localparam int LINE_W = 256;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam logic PORT_ICACHE = 1'b0;
   localparam logic PORT_DCACHE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
//============================================================================
// rr_arb2: combinational two-requester round-robin picker
// Revision: 1.0
//============================================================================
module rr_arb2
   import mem_if_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt_valid,
   output logic       gnt_idx
);

   always_comb begin
      gnt_valid = |req;
      gnt_idx   = PORT_ICACHE;
      // On a tie the port that did not win last time goes first
      if (req == 2'b11) begin
         gnt_idx = ~last;
      end else if (req[1]) begin
         gnt_idx = PORT_DCACHE;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
//============================================================================
// mem_arbiter: shares one line-wide data memory between icache and dcache
// Revision: 1.0
//============================================================================
module mem_arbiter #(
   parameter int ADDR_W  = mem_if_pkg::ADDR_W,
   parameter int LINE_W  = mem_if_pkg::LINE_W,
   parameter int TIMEOUT = 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              p0_enable_i,
   input  logic              p0_write_i,
   input  logic [ADDR_W-1:0] p0_addr_i,
   input  logic [LINE_W-1:0] p0_data_i,
   output logic [LINE_W-1:0] p0_data_o,
   output logic              p0_ack_o,
   input  logic              p1_enable_i,
   input  logic              p1_write_i,
   input  logic [ADDR_W-1:0] p1_addr_i,
   input  logic [LINE_W-1:0] p1_data_i,
   output logic [LINE_W-1:0] p1_data_o,
   output logic              p1_ack_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i,
   output logic              owner_o,
   output logic              busy_o,
   output logic              err_o
);

   import mem_if_pkg::*;

   localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   logic              r_owner;
   logic              r_last;
   logic              r_write;
   logic              r_err;
   logic [ADDR_W-1:0] r_addr;
   logic [LINE_W-1:0] r_data;
   logic [7:0]        r_cnt;
   logic              w_gnt_valid;
   logic              w_gnt_idx;
   logic              w_grant;
   logic              w_done;
   logic              w_timeout;

   rr_arb2 u_rr_arb2 (
      .req       ({p1_enable_i, p0_enable_i}),
      .last      (r_last),
      .gnt_valid (w_gnt_valid),
      .gnt_idx   (w_gnt_idx)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_done      = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_gnt_valid) begin
               w_state_nxt = BUSY;
               w_grant     = 1'b1;
            end
         end
         BUSY: begin
            // An ack arriving in the final allowed cycle still completes normally
            if (mem_ack_i) begin
               w_state_nxt = IDLE;
               w_done      = 1'b1;
            end else if (r_cnt == c_TO_LAST) begin
               w_state_nxt = IDLE;
               w_done      = 1'b1;
               w_timeout   = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_owner <= PORT_ICACHE;
         r_last  <= PORT_DCACHE;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_grant) begin
            r_owner <= w_gnt_idx;
            r_write <= (w_gnt_idx == PORT_DCACHE) ? p1_write_i : p0_write_i;
            r_addr  <= (w_gnt_idx == PORT_DCACHE) ? p1_addr_i  : p0_addr_i;
            r_data  <= (w_gnt_idx == PORT_DCACHE) ? p1_data_i  : p0_data_i;
            r_cnt   <= '0;
         end else if (r_state == BUSY) begin
            r_cnt <= r_cnt + 8'd1;
         end
         if (w_done) begin
            r_last <= r_owner;
         end
         if (w_timeout) begin
            r_err <= 1'b1;
         end
      end
   end

   assign busy_o       = (r_state == BUSY);
   assign mem_enable_o = busy_o;
   assign mem_write_o  = r_write;
   assign mem_addr_o   = r_addr;
   assign mem_data_o   = r_data;
   assign owner_o      = r_owner;
   assign err_o        = r_err;

   // An owner that dropped its request before the ack does not see the pulse
   assign p0_ack_o  = mem_ack_i & busy_o & (r_owner == PORT_ICACHE) & p0_enable_i;
   assign p1_ack_o  = mem_ack_i & busy_o & (r_owner == PORT_DCACHE) & p1_enable_i;
   assign p0_data_o = mem_data_i;
   assign p1_data_o = mem_data_i;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
//============================================================================
// tb_mem_arbiter: directed and randomized checks of mem_arbiter
// Revision: 1.0
//============================================================================
module tb_mem_arbiter;

   localparam int TO = 20;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         p0_enable_i, p0_write_i, p1_enable_i, p1_write_i;
   logic [31:0]  p0_addr_i, p1_addr_i;
   logic [255:0] p0_data_i, p1_data_i;
   logic [255:0] p0_data_o, p1_data_o;
   logic         p0_ack_o, p1_ack_o;
   logic         mem_enable_o, mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic [255:0] mem_data_i;
   logic         mem_ack_i;
   logic         owner_o, busy_o, err_o;

   always #5 clk_i = ~clk_i;

   mem_arbiter #(.ADDR_W(32), .LINE_W(256), .TIMEOUT(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .p0_enable_i(p0_enable_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i),
      .p0_data_i(p0_data_i), .p0_data_o(p0_data_o), .p0_ack_o(p0_ack_o),
      .p1_enable_i(p1_enable_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
      .p1_data_i(p1_data_i), .p1_data_o(p1_data_o), .p1_ack_o(p1_ack_o),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
      .owner_o(owner_o), .busy_o(busy_o), .err_o(err_o)
   );

   // Reference model: one outstanding transaction record plus fairness/err state
   bit           m_busy, m_owner, m_last, m_write, m_err;
   logic [31:0]  m_addr;
   logic [255:0] m_data;
   int           m_age;

   int n_checks = 0;
   int n_errors = 0;
   bit resp_on = 1'b0;
   int resp_cnt = 0;
   int resp_target = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chka(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chkd(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [255:0] rand_line();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_owner = 0; m_last = 1; m_write = 0; m_err = 0;
      m_addr = '0; m_data = '0; m_age = 0;
   endtask

   task automatic model_edge();
      if (!m_busy) begin
         if (p0_enable_i || p1_enable_i) begin
            if (p0_enable_i && p1_enable_i) m_owner = !m_last;
            else                            m_owner = p1_enable_i;
            m_write = m_owner ? p1_write_i : p0_write_i;
            m_addr  = m_owner ? p1_addr_i  : p0_addr_i;
            m_data  = m_owner ? p1_data_i  : p0_data_i;
            m_busy  = 1;
            m_age   = 0;
         end
      end else begin
         m_age++;
         if (mem_ack_i) begin
            m_busy = 0; m_last = m_owner;
         end else if (m_age >= TO) begin
            m_busy = 0; m_last = m_owner; m_err = 1;
         end
      end
   endtask

   task automatic compare();
      bit e0, e1;
      e0 = mem_ack_i && m_busy && !m_owner && p0_enable_i;
      e1 = mem_ack_i && m_busy &&  m_owner && p1_enable_i;
      chk1("mem_enable", mem_enable_o, m_busy);
      chk1("busy", busy_o, m_busy);
      chk1("err", err_o, m_err);
      chk1("p0_ack", p0_ack_o, e0);
      chk1("p1_ack", p1_ack_o, e1);
      chkd("p0_rdata", p0_data_o, mem_data_i);
      chkd("p1_rdata", p1_data_o, mem_data_i);
      if (m_busy) begin
         chk1("owner", owner_o, m_owner);
         chk1("mem_write", mem_write_o, m_write);
         chka("mem_addr", mem_addr_o, m_addr);
         chkd("mem_wdata", mem_data_o, m_data);
      end
   endtask

   // Memory responder: acks after a random latency, sometimes past the timeout
   task automatic drive_mem();
      mem_data_i = rand_line();
      mem_ack_i  = 1'b0;
      if (mem_enable_o) begin
         if (resp_cnt >= resp_target) begin
            mem_ack_i   = 1'b1;
            resp_cnt    = 0;
            resp_target = $urandom_range(0, TO + 4);
         end else begin
            resp_cnt++;
         end
      end else begin
         resp_cnt = 0;
         if ($urandom_range(0, 7) == 0) mem_ack_i = 1'b1;
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      if (rst_i) model_edge();
      #1;
      if (resp_on) drive_mem();
      @(negedge clk_i);
      compare();
   endtask

   task automatic ack_now(input logic exp0, input logic exp1);
      mem_data_i = rand_line();
      mem_ack_i  = 1'b1;
      #1;
      chk1("ack_pulse_p0", p0_ack_o, exp0);
      chk1("ack_pulse_p1", p1_ack_o, exp1);
      step();
      mem_ack_i = 1'b0;
      chk1("idle_after_ack", busy_o, 1'b0);
      chk1("bubble_enable", mem_enable_o, 1'b0);
   endtask

   task automatic new_req(input int n);
      if (n == 0) begin
         p0_enable_i = 1; p0_write_i = 0; p0_addr_i = $urandom; p0_data_i = rand_line();
      end else begin
         p1_enable_i = 1; p1_write_i = 1'($urandom_range(0, 1));
         p1_addr_i = $urandom; p1_data_i = rand_line();
      end
   endtask

   task automatic do_reset();
      rst_i = 0;
      p0_enable_i = 0; p0_write_i = 0; p0_addr_i = '0; p0_data_i = '0;
      p1_enable_i = 0; p1_write_i = 0; p1_addr_i = '0; p1_data_i = '0;
      mem_ack_i = 0; mem_data_i = '0;
      model_reset();
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1;
   endtask

   initial begin
      bit a0, a1;
      do_reset();
      chk1("rst_enable", mem_enable_o, 1'b0);
      chk1("rst_busy", busy_o, 1'b0);
      chk1("rst_err", err_o, 1'b0);
      chk1("rst_owner", owner_o, 1'b0);
      chk1("rst_write", mem_write_o, 1'b0);
      chka("rst_addr", mem_addr_o, 32'h0);
      chkd("rst_wdata", mem_data_o, 256'h0);

      // Single read on port 1
      p1_enable_i = 1; p1_write_i = 0; p1_addr_i = 32'h0000_0400; p1_data_i = '0;
      step();
      chk1("t1_enable", mem_enable_o, 1'b1);
      chka("t1_addr", mem_addr_o, 32'h400);
      chk1("t1_owner", owner_o, 1'b1);
      repeat (9) step();
      ack_now(1'b0, 1'b1);
      p1_enable_i = 0;
      step();

      // Tie out of reset, then strict alternation while both keep requesting
      do_reset();
      p0_enable_i = 1; p0_addr_i = 32'h100;
      p1_enable_i = 1; p1_addr_i = 32'h200;
      for (int k = 0; k < 4; k++) begin
         step();
         chk1("t2_owner", owner_o, 1'(k % 2));
         chka("t2_addr", mem_addr_o, (k % 2 == 1) ? 32'h200 : 32'h100);
         step();
         step();
         ack_now(k % 2 == 0, k % 2 == 1);
      end
      p0_enable_i = 0; p1_enable_i = 0;
      step();

      // Dcache writeback followed by refill
      p1_enable_i = 1; p1_write_i = 1; p1_addr_i = 32'h800; p1_data_i = {8{32'hA5A5_A5A5}};
      step();
      chk1("t3_wb_write", mem_write_o, 1'b1);
      chka("t3_wb_addr", mem_addr_o, 32'h800);
      chkd("t3_wb_data", mem_data_o, {8{32'hA5A5_A5A5}});
      step(); step();
      ack_now(1'b0, 1'b1);
      p1_write_i = 0; p1_addr_i = 32'hC00;
      step();
      chk1("t3_rf_enable", mem_enable_o, 1'b1);
      chk1("t3_rf_write", mem_write_o, 1'b0);
      chka("t3_rf_addr", mem_addr_o, 32'hC00);
      step();
      ack_now(1'b0, 1'b1);
      p1_enable_i = 0;
      step();

      // Owner abort
      p0_enable_i = 1; p0_addr_i = 32'h40;
      step(); step(); step();
      p0_enable_i = 0;
      step(); step();
      chk1("t4_hold_enable", mem_enable_o, 1'b1);
      ack_now(1'b0, 1'b0);
      step();

      // Timeout: exactly TO busy cycles, err stays set, later requests served
      p0_enable_i = 1; p0_addr_i = 32'h80;
      for (int i = 1; i <= TO; i++) step();
      chk1("t5_last_busy_cycle", mem_enable_o, 1'b1);
      step();
      chk1("t5_dropped", mem_enable_o, 1'b0);
      chk1("t5_err", err_o, 1'b1);
      p0_enable_i = 0; p1_enable_i = 1; p1_write_i = 0; p1_addr_i = 32'h900;
      step();
      chk1("t5_served_owner", owner_o, 1'b1);
      chk1("t5_err_sticky", err_o, 1'b1);
      ack_now(1'b0, 1'b1);
      p1_enable_i = 0;
      step();

      // Async reset mid-transaction
      p0_enable_i = 1; p0_addr_i = 32'h10;
      step(); step();
      rst_i = 0;
      #1;
      chk1("t6_enable", mem_enable_o, 1'b0);
      chk1("t6_busy", busy_o, 1'b0);
      chk1("t6_err", err_o, 1'b0);
      chk1("t6_owner", owner_o, 1'b0);
      chka("t6_addr", mem_addr_o, 32'h0);
      model_reset();
      p1_enable_i = 1; p1_write_i = 0; p1_addr_i = 32'h20;
      @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1;
      step();
      chk1("t6_tie_owner", owner_o, 1'b0);
      chka("t6_tie_addr", mem_addr_o, 32'h10);
      step();
      ack_now(1'b1, 1'b0);
      p0_enable_i = 0;

      // Randomized traffic
      resp_on = 1'b1;
      repeat (4000) begin
         step();
         a0 = p0_ack_o;
         a1 = p1_ack_o;
         if (p0_enable_i) begin
            if (a0) begin
               if ($urandom_range(0, 2) == 0) p0_enable_i = 0;
               else new_req(0);
            end else if ($urandom_range(0, 63) == 0) p0_enable_i = 0;
         end else if ($urandom_range(0, 3) == 0) new_req(0);
         if (p1_enable_i) begin
            if (a1) begin
               if ($urandom_range(0, 2) == 0) p1_enable_i = 0;
               else new_req(1);
            end else if ($urandom_range(0, 63) == 0) p1_enable_i = 0;
         end else if ($urandom_range(0, 3) == 0) new_req(1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
